// File: rtl/tdm_demux_if.sv
// tdm_demux_if: serial TDM link in, per-channel holding registers and status out.
// master drives the link side; slave is the demux.
interface tdm_demux_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 1
);
    logic [DATA_W-1:0]        din;
    logic                     din_valid;
    logic                     frame_sync;
    logic [NUM_CH*DATA_W-1:0] dout;
    logic [NUM_CH-1:0]        dout_valid;
    logic                     frame_done;
    logic                     locked;
    logic                     sync_err;
    modport master (
        output din, din_valid, frame_sync,
        input  dout, dout_valid, frame_done, locked, sync_err
    );
    modport slave (
        input  din, din_valid, frame_sync,
        output dout, dout_valid, frame_done, locked, sync_err
    );
endinterface

// File: rtl/tdm_demux.sv
// tdm_demux: locks onto frame_sync, tracks the slot and routes each beat to its channel register.
// Define TDM_DEMUX_FRAME_ALIGN_EN to buffer a frame in shadow registers and publish it whole.
module tdm_demux #(
    parameter int NUM_CH   = 4,
    parameter int DATA_W   = 1,
    parameter int MAX_MISS = 2
) (
    input logic       clk,
    input logic       rst_n,
    tdm_demux_if.slave bus
);
    localparam int SW = $clog2(NUM_CH);
    localparam int MW = $clog2(MAX_MISS + 1);
    localparam int W  = NUM_CH * DATA_W;

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t        state, state_n;
    logic [SW-1:0] slot, slot_n, ch;
    logic [MW-1:0] miss, miss_n;
    logic          wr, fd, se;
    logic [W-1:0]      dout_r;
    logic [NUM_CH-1:0] dv_r;
    logic              fd_r, se_r, lk_r;

    always_comb begin
        state_n = state;
        slot_n  = slot;
        miss_n  = miss;
        wr      = 1'b0;
        ch      = '0;
        fd      = 1'b0;
        se      = 1'b0;
        if (bus.din_valid) begin
            if (state == HUNT) begin
                if (bus.frame_sync) begin
                    wr      = 1'b1;
                    slot_n  = SW'(1);
                    miss_n  = '0;
                    state_n = LOCKED;
                end
            end else if (slot == '0) begin
                wr     = 1'b1;
                slot_n = SW'(1);
                miss_n = bus.frame_sync ? '0 : (miss == MW'(MAX_MISS) ? miss : miss + MW'(1));
                if (!bus.frame_sync && miss_n == MW'(MAX_MISS)) begin
                    state_n = HUNT;
                    slot_n  = '0;
                end
            end else if (bus.frame_sync) begin
                // misplaced mark: restart the frame with this beat as slot 0
                wr     = 1'b1;
                se     = 1'b1;
                slot_n = SW'(1);
                miss_n = '0;
            end else begin
                wr     = 1'b1;
                ch     = slot;
                fd     = slot == SW'(NUM_CH - 1);
                slot_n = fd ? '0 : slot + SW'(1);
            end
        end
    end

`ifdef TDM_DEMUX_FRAME_ALIGN_EN
    logic [W-1:0] shadow, shadow_n;

    always_comb begin
        shadow_n = shadow;
        if (wr) shadow_n[ch*DATA_W +: DATA_W] = bus.din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            dout_r <= '0;
            dv_r   <= '0;
        end else begin
            shadow <= shadow_n;
            dv_r   <= {NUM_CH{fd}};
            if (fd) dout_r <= shadow_n;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_r <= '0;
            dv_r   <= '0;
        end else begin
            dv_r <= wr ? NUM_CH'(1) << ch : '0;
            if (wr) dout_r[ch*DATA_W +: DATA_W] <= bus.din;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
            slot  <= '0;
            miss  <= '0;
            fd_r  <= 1'b0;
            se_r  <= 1'b0;
            lk_r  <= 1'b0;
        end else begin
            state <= state_n;
            slot  <= slot_n;
            miss  <= miss_n;
            fd_r  <= fd;
            se_r  <= se;
            lk_r  <= state == LOCKED;
        end
    end

    assign bus.dout       = dout_r;
    assign bus.dout_valid = dv_r;
    assign bus.frame_done = fd_r;
    assign bus.sync_err   = se_r;
    assign bus.locked     = lk_r;
endmodule
